// File: rtl/dc_line_responder.sv
// Purpose: memory-side responder for the data cache: word-per-beat refills and buffered line writebacks.
// Latency: first refill beat LATENCY+1 cycles after the request is seen in IDLE; a writeback drains in 8 cycles.
// Backpressure: none; one writeback buffer only, and an extra writeback while it is full is dropped and flagged in wb_overflow.
module dc_line_responder #(
    parameter int MEM_WORDS_LOG2 = 14,
    parameter int LATENCY        = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_request,
    input  logic [31:0]  request_addr,
    output logic [31:0]  requested_data,
    output logic         req_valid,
    input  logic         is_wb,
    input  logic [31:0]  wb_addr,
    input  logic [255:0] wb_data,
    output logic         wb_full,
    output logic         wb_overflow,
    output logic         busy
);
    // The line tag keeps only the address bits that index the store, so aliases compare equal.
    localparam int LW = MEM_WORDS_LOG2 - 3;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, STREAM, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   req_line;
    logic [LW-1:0]   wb_line;
    logic [255:0]    wb_buf;
    logic [CW-1:0]   lat_cnt;
    logic [2:0]      beat_cnt;
    logic [2:0]      drain_cnt;
    logic [31:0]     mem [0:(1<<MEM_WORDS_LOG2)-1];

    logic [LW-1:0]   cur_line;
    logic [2:0]      word_sel;
    logic            line_hit;
    logic            beat;
    logic            drain_done;
    logic            wb_accept;
    logic            fwd_hit;
    logic            relatch;
    logic            unused_bits;

    assign cur_line   = request_addr[MEM_WORDS_LOG2+1:5];
    assign word_sel   = request_addr[4:2];
    assign line_hit   = (cur_line == req_line);
    assign beat       = (state == STREAM) && is_request && line_hit;
    assign drain_done = (state == DRAIN) && (drain_cnt == 3'd7);
    // The buffer can take a new line in the same cycle the old one finishes draining.
    assign wb_accept  = is_wb && (!wb_full || drain_done);
    assign fwd_hit    = wb_full && (wb_line == cur_line);
    // A new miss: request from IDLE, or the cache moved to another line mid-stream.
    assign relatch    = is_request && ((state == IDLE) || ((state == STREAM) && !line_hit));
    assign unused_bits = ^{request_addr[31:MEM_WORDS_LOG2+2], request_addr[1:0],
                           wb_addr[31:MEM_WORDS_LOG2+2], wb_addr[4:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a pending request beats a pending drain out of IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_request)   state_nxt = WAIT;
                else if (wb_full) state_nxt = DRAIN;
            end
            WAIT: begin
                if (!is_request)       state_nxt = IDLE;
                else if (lat_cnt == '0) state_nxt = STREAM;
            end
            STREAM: begin
                if (!is_request)             state_nxt = IDLE;
                else if (!line_hit)          state_nxt = WAIT;
                else if (beat_cnt == 3'd7)   state_nxt = IDLE;
            end
            DRAIN: begin
                if (drain_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: the returned word is selected combinationally, from the buffer if it holds the line.
    always_comb begin
        busy           = (state != IDLE);
        req_valid      = beat;
        requested_data = '0;
        if (beat) begin
            if (fwd_hit) requested_data = wb_buf[{word_sel, 5'b0} +: 32];
            else         requested_data = mem[request_addr[MEM_WORDS_LOG2+1:2]];
        end
    end

    // Counters, latched request line and the writeback buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_line    <= '0;
            lat_cnt     <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            wb_line     <= '0;
            wb_buf      <= '0;
            wb_full     <= 1'b0;
            wb_overflow <= 1'b0;
        end else begin
            if (relatch) begin
                req_line <= cur_line;
                lat_cnt  <= CW'(LATENCY - 1);
                beat_cnt <= '0;
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (beat)           beat_cnt  <= beat_cnt + 3'd1;
            if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
            if (wb_accept) begin
                wb_line <= wb_addr[MEM_WORDS_LOG2+1:5];
                wb_buf  <= wb_data;
                wb_full <= 1'b1;
            end else if (drain_done) begin
                wb_full <= 1'b0;
            end
            if (is_wb && !wb_accept) wb_overflow <= 1'b1;
        end
    end

    // Backing store write port: one buffered word per DRAIN cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && (state == DRAIN))
            mem[{wb_line, drain_cnt}] <= wb_buf[{drain_cnt, 5'b0} +: 32];
    end
endmodule

// File: tb/tb_dc_line_responder.sv
// Directed bench for dc_line_responder: refill timing, writeback drain, forwarding, overflow, reset, abort/restart.
module tb_dc_line_responder;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         is_request = 1'b0;
    logic [31:0]  request_addr = '0;
    logic [31:0]  requested_data;
    logic         req_valid;
    logic         is_wb = 1'b0;
    logic [31:0]  wb_addr = '0;
    logic [255:0] wb_data = '0;
    logic         wb_full;
    logic         wb_overflow;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;

    dc_line_responder #(.MEM_WORDS_LOG2(14), .LATENCY(4)) dut (
        .clk(clk), .reset(reset),
        .is_request(is_request), .request_addr(request_addr),
        .requested_data(requested_data), .req_valid(req_valid),
        .is_wb(is_wb), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_full(wb_full), .wb_overflow(wb_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = base + step * k;
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            is_request = 1'b0;
            is_wb      = 1'b0;
        end
    endtask

    // One writeback from IDLE; buffer fills next cycle, drain runs cycles 2..9, idle again at 10.
    task automatic writeback(input string pfx, input logic [31:0] addr, input logic [255:0] data);
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            is_request = 1'b0;
            is_wb      = (c == 0);
            wb_addr    = addr;
            wb_data    = data;
            #1;
            if (c == 1)  check({pfx, "_full"}, 32'(wb_full), 32'd1);
            if (c == 2)  check({pfx, "_drain_busy"}, 32'(busy), 32'd1);
            if (c == 9)  check({pfx, "_full_last"}, 32'(wb_full), 32'd1);
            if (c == 10) begin
                check({pfx, "_empty"}, 32'(wb_full), 32'd0);
                check({pfx, "_idle"}, 32'(busy), 32'd0);
            end
        end
        is_wb = 1'b0;
    endtask

    // Full-line refill, sequential words; beats expected on cycles 5..12, idle on 13.
    task automatic refill(input string pfx, input logic [31:0] base, input logic [255:0] expv,
                          input bit with_wb, input logic [31:0] wa, input logic [255:0] wd);
        logic [31:0] ew;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            is_request   = (c <= 12);
            request_addr = (c >= 5) ? base + 32'(4 * (c - 5)) : base;
            is_wb        = with_wb && (c == 0);
            wb_addr      = wa;
            wb_data      = wd;
            #1;
            if (c >= 5 && c <= 12) begin
                ew = expv[32*(c-5) +: 32];
                check({pfx, "_vld"}, 32'(req_valid), 32'd1);
                check({pfx, "_dat"}, requested_data, ew);
            end else begin
                check({pfx, "_novld"}, 32'(req_valid), 32'd0);
                check({pfx, "_zero"}, requested_data, 32'd0);
            end
            if (with_wb && c == 1) check({pfx, "_wbfull"}, 32'(wb_full), 32'd1);
            if (c == 13) check({pfx, "_busy_end"}, 32'(busy), 32'd0);
        end
        is_request = 1'b0;
        is_wb      = 1'b0;
    endtask

    initial begin
        // Bound the whole run.
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] line_a, line_b, line_c, line_d;
        line_a = mk_line(32'hA000_0000, 32'd1);
        line_b = mk_line(32'hB000_0000, 32'd1);
        line_c = mk_line(32'hC000_0000, 32'd1);
        line_d = mk_line(32'hD000_0000, 32'd1);

        // Reset state.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_vld", 32'(req_valid), 32'd0);
        check("rst_dat", requested_data, 32'd0);
        check("rst_full", 32'(wb_full), 32'd0);
        check("rst_ovf", 32'(wb_overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 1: preload store[0x10+k]=k through a writeback, then refill line 0x40.
        writeback("t1_pre", 32'h40, mk_line(32'd0, 32'd1));
        refill("t1", 32'h40, mk_line(32'd0, 32'd1), 1'b0, 32'd0, 256'd0);

        // 2: writeback line 0x80 with k*0x11111111 and read it back.
        writeback("t2_wb", 32'h80, mk_line(32'd0, 32'h1111_1111));
        refill("t2", 32'h80, mk_line(32'd0, 32'h1111_1111), 1'b0, 32'd0, 256'd0);

        // 3: writeback and refill of line 0x100 in the same cycle; beats forwarded from the buffer.
        refill("t3_fwd", 32'h100, line_d, 1'b1, 32'h100, line_d);
        idle(8);
        @(negedge clk); #1;
        check("t3_drained", 32'(wb_full), 32'd0);
        check("t3_idle", 32'(busy), 32'd0);
        refill("t3_store", 32'h100, line_d, 1'b0, 32'd0, 256'd0);

        // 4: second writeback while full is dropped; line 0x200 keeps its earlier contents.
        writeback("t4_pre", 32'h200, line_c);
        @(negedge clk);
        is_wb = 1'b1; wb_addr = 32'h180; wb_data = line_a;
        @(negedge clk);
        is_wb = 1'b1; wb_addr = 32'h200; wb_data = line_b;
        #1;
        check("t4_full", 32'(wb_full), 32'd1);
        check("t4_ovf_before", 32'(wb_overflow), 32'd0);
        @(negedge clk);
        is_wb = 1'b0;
        #1;
        check("t4_ovf", 32'(wb_overflow), 32'd1);
        idle(7);
        @(negedge clk); #1;
        check("t4_drained", 32'(wb_full), 32'd0);
        check("t4_ovf_sticky", 32'(wb_overflow), 32'd1);
        refill("t4_first", 32'h180, line_a, 1'b0, 32'd0, 256'd0);
        refill("t4_kept", 32'h200, line_c, 1'b0, 32'd0, 256'd0);
        check("t4_ovf_still", 32'(wb_overflow), 32'd1);

        // 5: reset on stream beat 3 with a writeback buffered; then a clean refill.
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            is_request   = (c <= 7);
            request_addr = (c >= 5) ? 32'h40 + 32'(4 * (c - 5)) : 32'h40;
            is_wb        = (c == 0);
            wb_addr      = 32'h300;
            wb_data      = line_b;
            reset        = (c == 7);
            #1;
            if (c == 1) check("t5_full", 32'(wb_full), 32'd1);
            if (c == 5 || c == 6) check("t5_dat", requested_data, 32'(c - 5));
            if (c == 8) begin
                check("t5_vld", 32'(req_valid), 32'd0);
                check("t5_busy", 32'(busy), 32'd0);
                check("t5_full0", 32'(wb_full), 32'd0);
                check("t5_ovf0", 32'(wb_overflow), 32'd0);
            end
        end
        refill("t5_after", 32'h40, mk_line(32'd0, 32'd1), 1'b0, 32'd0, 256'd0);

        // 6a: request dropped during WAIT aborts without any beat.
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            is_request   = (c <= 2);
            request_addr = 32'h40;
            #1;
            check("t6a_novld", 32'(req_valid), 32'd0);
            if (c == 3) check("t6a_wait", 32'(busy), 32'd1);
            if (c == 4) check("t6a_idle", 32'(busy), 32'd0);
        end

        // 6b: line changes to 0x80 on the fourth beat; WAIT restarts, then 8 fresh beats.
        for (int c = 0; c <= 21; c++) begin
            @(negedge clk);
            is_request = (c <= 20);
            if (c < 5)       request_addr = 32'h40;
            else if (c < 8)  request_addr = 32'h40 + 32'(4 * (c - 5));
            else if (c < 13) request_addr = 32'h80;
            else             request_addr = 32'h80 + 32'(4 * (c - 13));
            #1;
            if (c >= 5 && c < 8) begin
                check("t6b_old_vld", 32'(req_valid), 32'd1);
                check("t6b_old_dat", requested_data, 32'(c - 5));
            end else if (c >= 13 && c <= 20) begin
                check("t6b_new_vld", 32'(req_valid), 32'd1);
                check("t6b_new_dat", requested_data, 32'h1111_1111 * 32'(c - 13));
            end else begin
                check("t6b_novld", 32'(req_valid), 32'd0);
            end
            if (c == 10) check("t6b_rewait", 32'(busy), 32'd1);
            if (c == 21) check("t6b_idle", 32'(busy), 32'd0);
        end
        is_request = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
